// File: rtl/wspr_pkg.sv
// Shared constants and types for the WSPR tone sequencer.
package wspr_pkg;

  // Symbols per WSPR frame.
  localparam int NSYM = 162;

  // 8192/12000 s per symbol at a 76.8 MHz system clock.
  localparam int SYMBOL_CYCLES_DEFAULT = 52428800;

  // Default width of the per-tone phase-increment delta.
  localparam int STEP_W_DEFAULT = 16;

  // Sequencer states; the top carries them as plain 2-bit constants.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TX    = 2'd2,
    ST_DONE  = 2'd3
  } wspr_state_e;

  // One 4-FSK channel symbol, 0..3.
  typedef logic [1:0] wspr_sym_t;

endpackage

// File: rtl/wspr_tone_sequencer_if.sv
// Control/status bundle between a frame controller and the tone sequencer.
//
// Handshake semantics: there is no valid/ready pair. start, sync and abort
// are single-cycle request pulses, sampled on the rising clock edge and acted
// on only in the states that accept them; all other cycles drop them. sym_we
// is a write strobe that lands only in IDLE with sym_addr < NSYM. nco_rst and
// done are single-cycle output pulses. tx_en and busy are levels. state is a
// read-only debug view of the FSM.
interface wspr_tone_sequencer_if #(
  parameter int STEP_W = 16
);
  import wspr_pkg::*;

  logic              sym_we;
  logic [7:0]        sym_addr;
  wspr_sym_t         sym_data;
  logic [31:0]       base_phi;
  logic [STEP_W-1:0] tone_step;
  logic              start;
  logic              sync;
  logic              abort;

  logic [31:0]       phi;
  logic              nco_rst;
  logic              tx_en;
  logic              busy;
  logic              done;
  logic [7:0]        sym_idx;
  logic [1:0]        state;

  modport master (
    output sym_we, sym_addr, sym_data, base_phi, tone_step, start, sync, abort,
    input  phi, nco_rst, tx_en, busy, done, sym_idx, state
  );

  modport slave (
    input  sym_we, sym_addr, sym_data, base_phi, tone_step, start, sync, abort,
    output phi, nco_rst, tx_en, busy, done, sym_idx, state
  );

endinterface

// File: rtl/wspr_sym_ram.sv
// NSYM x 2-bit symbol buffer: one write port, one registered read port.
// A write and a read to the same address in one cycle return the new data,
// so a written symbol is visible on the read port the following cycle.
module wspr_sym_ram
  import wspr_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  logic [7:0] wr_addr,
  input  wspr_sym_t wr_data,
  input  logic [7:0] rd_addr,
  output wspr_sym_t rd_data
);

  wspr_sym_t mem [NSYM];

  // Store a symbol; the caller guarantees wr_addr < NSYM when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read with same-cycle write forwarding.
  always_ff @(posedge clk) begin
    if (we && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/wspr_tone_sequencer.sv
// WSPR 4-FSK tone sequencer: walks a preloaded 162-symbol frame and drives
// the NCO phase increment phi = base + symbol * tone_step, one symbol per
// SYMBOL_CYCLES clocks, after an arm (start) and an even-minute sync pulse.
// SYMBOL_CYCLES must be at least 2 so the next symbol can be prefetched from
// the registered buffer before each boundary.
module wspr_tone_sequencer
  import wspr_pkg::*;
#(
  parameter int SYMBOL_CYCLES = SYMBOL_CYCLES_DEFAULT,
  parameter int STEP_W        = STEP_W_DEFAULT
) (
  input logic clk,
  input logic rst,
  wspr_tone_sequencer_if.slave bus
);

  localparam int CNT_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [7:0] LAST_IDX = 8'(NSYM - 1);
  localparam logic [7:0] NSYM_8   = 8'(NSYM);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_TX    = ST_TX;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       base_l;
  logic [STEP_W-1:0] step_l;
  logic [31:0]       phi_r;
  logic              nco_rst_r;
  logic              tx_en_r;
  logic              busy_r;
  logic              done_r;
  logic [7:0]        sym_idx_r;

  logic              ram_we;
  logic [7:0]        rd_addr;
  wspr_sym_t         rd_sym;
  logic [STEP_W+1:0] tone_prod;
  logic [31:0]       phi_next;

  // The buffer is only writable while no frame is pending or running.
  assign ram_we = bus.sym_we && (state == S_IDLE) && (bus.sym_addr < NSYM_8);

  // Prefetch address: symbol 0 while waiting for sync, the next symbol during TX.
  always_comb begin
    rd_addr = 8'd0;
    if ((state == S_TX) && (sym_idx_r != LAST_IDX)) begin
      rd_addr = sym_idx_r + 8'd1;
    end
  end

  wspr_sym_ram u_sym_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (bus.sym_addr),
    .wr_data (bus.sym_data),
    .rd_addr (rd_addr),
    .rd_data (rd_sym)
  );

  // Tone for the prefetched symbol; the 32-bit sum wraps modulo 2^32.
  always_comb begin
    tone_prod = {{STEP_W{1'b0}}, rd_sym} * {2'b00, step_l};
    phi_next  = base_l + 32'(tone_prod);
  end

  // Frame FSM, symbol counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      base_l    <= '0;
      step_l    <= '0;
      phi_r     <= '0;
      nco_rst_r <= 1'b0;
      tx_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sym_idx_r <= '0;
    end else begin
      nco_rst_r <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_ARMED;
            busy_r <= 1'b1;
            base_l <= bus.base_phi;
            step_l <= bus.tone_step;
          end
        end
        S_ARMED: begin
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            phi_r  <= base_l;
          end else if (bus.sync) begin
            state     <= S_TX;
            nco_rst_r <= 1'b1;
            sym_idx_r <= '0;
            cnt       <= CNT_RELOAD;
            tx_en_r   <= 1'b1;
            phi_r     <= phi_next;
          end
        end
        S_TX: begin
          if (bus.abort) begin
            state   <= S_IDLE;
            tx_en_r <= 1'b0;
            busy_r  <= 1'b0;
            phi_r   <= base_l;
          end else if (cnt == '0) begin
            if (sym_idx_r != LAST_IDX) begin
              sym_idx_r <= sym_idx_r + 8'd1;
              cnt       <= CNT_RELOAD;
              phi_r     <= phi_next;
            end else begin
              state   <= S_DONE;
              done_r  <= 1'b1;
              tx_en_r <= 1'b0;
              busy_r  <= 1'b0;
              phi_r   <= base_l;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.phi     = phi_r;
  assign bus.nco_rst = nco_rst_r;
  assign bus.tx_en   = tx_en_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.sym_idx = sym_idx_r;
  assign bus.state   = state;

endmodule

// File: tb/tb_wspr_tone_sequencer.sv
// Directed bench for wspr_tone_sequencer with a queue-based output scoreboard.
module tb_wspr_tone_sequencer;
  import wspr_pkg::*;

  localparam int SC     = 4;
  localparam int STEP_W = 16;
  localparam int OBS_W  = 43;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wspr_tone_sequencer_if #(.STEP_W(STEP_W)) bus ();

  wspr_tone_sequencer #(
    .SYMBOL_CYCLES (SC),
    .STEP_W        (STEP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic [1:0] model_sym [NSYM];

  function automatic logic [31:0] model_phi(input logic [31:0] b,
                                            input logic [15:0] s,
                                            input logic [1:0] y);
    logic [17:0] p;
    p = {16'd0, y} * {2'b00, s};
    return b + {14'd0, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic write_sym(input int addr, input logic [1:0] data, input bit accepted);
    bus.sym_we   = 1'b1;
    bus.sym_addr = 8'(addr);
    bus.sym_data = data;
    tick(1);
    bus.sym_we = 1'b0;
    if (accepted) model_sym[addr] = data;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Expected TX stream for one frame, truncated to 'limit' TX cycles.
  task automatic push_frame(input logic [31:0] b, input logic [15:0] s, input int limit);
    for (int k = 0; k < NSYM * SC && k < limit; k++) begin
      int idx;
      idx = k / SC;
      exp_q.push_back({1'b0, 1'b1, (k == 0), 8'(idx), model_phi(b, s, model_sym[idx])});
    end
    if (limit >= NSYM * SC) exp_q.push_back({1'b1, 1'b0, 1'b0, 8'(NSYM - 1), b});
  endtask

  // Scoreboard monitor: every cycle the DUT transmits or signals done
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.tx_en === 1'b1 || bus.done === 1'b1)) begin
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] e;
      obs = {bus.done, bus.tx_en, bus.nco_rst, bus.sym_idx, bus.phi};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got done=%b tx_en=%b nco_rst=%b idx=%0d phi=%h expected no output",
                 obs[42], obs[41], obs[40], obs[39:32], obs[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL stream: got done=%b tx_en=%b nco_rst=%b idx=%0d phi=%h expected done=%b tx_en=%b nco_rst=%b idx=%0d phi=%h",
                   obs[42], obs[41], obs[40], obs[39:32], obs[31:0],
                   e[42], e[41], e[40], e[39:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    bus.sym_we = 1'b0; bus.sym_addr = '0; bus.sym_data = '0;
    bus.base_phi = '0; bus.tone_step = '0;
    bus.start = 1'b0; bus.sync = 1'b0; bus.abort = 1'b0;

    // Reset values
    rst = 1'b1;
    tick(3);
    check("rst_phi", 64'(bus.phi), 64'h0);
    check("rst_nco_rst", 64'(bus.nco_rst), 64'h0);
    check("rst_tx_en", 64'(bus.tx_en), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_sym_idx", 64'(bus.sym_idx), 64'h0);
    check("rst_state", 64'(bus.state), 64'(ST_IDLE));
    rst = 1'b0;

    // Load sym[i] = i % 4; out-of-range address is dropped
    for (int i = 0; i < NSYM; i++) write_sym(i, 2'(i % 4), 1'b1);
    write_sym(200, 2'd3, 1'b0);

    // sync alone in IDLE is ignored
    bus.sync = 1'b1;
    tick(1);
    bus.sync = 1'b0;
    check("idle_sync_state", 64'(bus.state), 64'(ST_IDLE));
    check("idle_sync_busy", 64'(bus.busy), 64'h0);

    // start + sync together: arms only
    bus.base_phi  = 32'h1000_0000;
    bus.tone_step = 16'd82;
    bus.start = 1'b1;
    bus.sync  = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.sync  = 1'b0;
    bus.base_phi  = 32'h2000_0000;
    bus.tone_step = 16'd7;
    check("armed_state", 64'(bus.state), 64'(ST_ARMED));
    check("armed_busy", 64'(bus.busy), 64'h1);
    check("armed_tx_en", 64'(bus.tx_en), 64'h0);
    tick(2);
    check("armed_hold_state", 64'(bus.state), 64'(ST_ARMED));
    check("armed_hold_tx_en", 64'(bus.tx_en), 64'h0);

    // Frame 1: full frame with latched base/step
    push_frame(32'h1000_0000, 16'd82, NSYM * SC);
    bus.sync = 1'b1;
    tick(1);
    bus.sync = 1'b0;
    check("tx0_nco_rst", 64'(bus.nco_rst), 64'h1);
    check("tx0_phi", 64'(bus.phi), 64'h1000_0000);
    tick(1);
    check("tx1_nco_rst", 64'(bus.nco_rst), 64'h0);
    tick(3);
    check("sym1_phi", 64'(bus.phi), 64'h1000_0052);
    tick(4);
    check("sym2_phi", 64'(bus.phi), 64'h1000_00A4);
    tick(4);
    check("sym3_phi", 64'(bus.phi), 64'h1000_00F6);
    write_sym(5, 2'd0, 1'b0);
    pulse_start();
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    check("done_seen", 64'(bus.done), 64'h1);
    check("done_tx_en", 64'(bus.tx_en), 64'h0);
    check("done_busy", 64'(bus.busy), 64'h0);
    check("done_phi", 64'(bus.phi), 64'h1000_0000);
    tick(1);
    check("post_done_state", 64'(bus.state), 64'(ST_IDLE));
    check("post_done_pulse", 64'(bus.done), 64'h0);

    // Frame 2: wrap-around phi, then abort on a symbol boundary
    write_sym(0, 2'd3, 1'b1);
    bus.base_phi  = 32'hFFFF_FFF0;
    bus.tone_step = 16'hFFFF;
    pulse_start();
    push_frame(32'hFFFF_FFF0, 16'hFFFF, 10 * SC + SC);
    bus.sync = 1'b1;
    tick(1);
    bus.sync = 1'b0;
    check("wrap_phi", 64'(bus.phi), 64'h0002_FFED);
    tick(10 * SC + SC - 1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("abort_state", 64'(bus.state), 64'(ST_IDLE));
    check("abort_tx_en", 64'(bus.tx_en), 64'h0);
    check("abort_busy", 64'(bus.busy), 64'h0);
    check("abort_done", 64'(bus.done), 64'h0);
    check("abort_sym_idx", 64'(bus.sym_idx), 64'd10);
    check("abort_phi", 64'(bus.phi), 64'hFFFF_FFF0);
    tick(3);

    // abort while ARMED
    pulse_start();
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("armed_abort_state", 64'(bus.state), 64'(ST_IDLE));
    check("armed_abort_busy", 64'(bus.busy), 64'h0);

    tick(5);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
